// File: rtl/io_loader.sv
// -----------------------------------------------------------------------------
// io_loader
//
// Byte-serial loader/dumper for a CPU program RAM.
//
// Load: bytes arriving on the receive side (rx_done/rx_data) are packed
// little-endian into BPW-byte words and written to consecutive RAM
// addresses starting at 0.  Writing the last word (DEPTH-1) hands the RAM
// to the CPU (sel=1) and pulses reset_cpu for one cycle.
//
// Dump: a level-high start (with no partial word pending) takes the RAM
// back (sel=0) and streams every word, lane 0 first, to the transmitter
// using tx_start/tx_done handshakes.  After the last byte the block parks
// in HOLD until start drops, so a held start gives exactly one dump.
//
// Optional feature (macro IO_LOADER_CHECKSUM_EN): after the last data
// byte a trailer byte holding the modulo-256 sum of all dumped bytes is
// sent before HOLD.
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous, active-high reset
//   start      : dump request (level)
//   rx_done    : one-cycle pulse, rx_data valid
//   rx_data    : received byte
//   tx_done    : one-cycle pulse, transmitter finished current byte
//   tx_start   : one-cycle pulse, transmitter latches tx_data
//   tx_data    : byte to transmit
//   ram_addr   : RAM address
//   ram_wdata  : RAM write data (8*BPW)
//   ram_we     : RAM write strobe, one cycle per word
//   ram_rdata  : RAM read data, valid the cycle after ram_addr
//   reset_cpu  : one-cycle pulse when the image load completes
//   sel        : RAM owner, 1 = CPU, 0 = loader
//   busy       : high in every state except IDLE
//   rx_err     : sticky, a byte arrived while the loader could not take it
// -----------------------------------------------------------------------------
module io_loader #(
  parameter int ADDR_W = 16,
  parameter int DEPTH  = 65536,
  parameter int BPW    = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                rx_done,
  input  logic [7:0]          rx_data,
  input  logic                tx_done,
  output logic                tx_start,
  output logic [7:0]          tx_data,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [8*BPW-1:0]    ram_wdata,
  output logic                ram_we,
  input  logic [8*BPW-1:0]    ram_rdata,
  output logic                reset_cpu,
  output logic                sel,
  output logic                busy,
  output logic                rx_err
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD,
    LATCH,
    SEND,
    WAIT_TX,
    HOLD
  } state_t;

  // Counters carry one extra bit so DEPTH-1 is representable even when
  // DEPTH equals 2**ADDR_W.
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);
  localparam logic [2:0]      BPW_CNT   = 3'(BPW);
  localparam logic [1:0]      LAST_LANE = 2'(BPW - 1);

  state_t              state;
  state_t              nxt;

  logic [ADDR_W:0]     wr_addr;
  logic [ADDR_W:0]     rd_addr;
  logic [2:0]          byte_cnt;
  logic [1:0]          lane;
  logic                sel_q;
  logic                reset_cpu_q;
  logic                rx_err_q;

  logic [8*BPW-1:0]    word;
  logic [8*BPW-1:0]    shreg;

  logic                word_full;

`ifdef IO_LOADER_CHECKSUM_EN
  logic [7:0]          sum;
  logic                trailer;
`endif

  assign word_full = ((byte_cnt + 3'd1) == BPW_CNT);

  assign sel       = sel_q;
  assign reset_cpu = reset_cpu_q;
  assign rx_err    = rx_err_q;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next state and state-decoded outputs.  All bus outputs are zero outside
  // the state that owns them, so reset forces them low at once.
  // ---------------------------------------------------------------------------
  always_comb begin
    nxt       = state;
    tx_start  = 1'b0;
    tx_data   = 8'd0;
    ram_addr  = '0;
    ram_wdata = '0;
    ram_we    = 1'b0;
    busy      = (state != IDLE);

    case (state)
      IDLE: begin
        // A received byte takes priority over a dump request.
        if (rx_done) begin
          if (word_full) nxt = WRITE;
        end else if (start && (byte_cnt == 3'd0)) begin
          nxt = RD;
        end
      end

      WRITE: begin
        ram_we    = 1'b1;
        ram_addr  = wr_addr[ADDR_W-1:0];
        ram_wdata = word;
        nxt       = IDLE;
      end

      RD: begin
        ram_addr = rd_addr[ADDR_W-1:0];
        nxt      = LATCH;
      end

      LATCH: begin
        nxt = SEND;
      end

      SEND: begin
        tx_start = 1'b1;
`ifdef IO_LOADER_CHECKSUM_EN
        tx_data  = trailer ? sum : shreg[7:0];
`else
        tx_data  = shreg[7:0];
`endif
        nxt      = WAIT_TX;
      end

      WAIT_TX: begin
        if (tx_done) begin
`ifdef IO_LOADER_CHECKSUM_EN
          if (trailer) begin
            nxt = HOLD;
          end else if (lane != LAST_LANE) begin
            nxt = SEND;
          end else if (rd_addr != LAST_ADDR) begin
            nxt = RD;
          end else begin
            nxt = SEND;
          end
`else
          if (lane != LAST_LANE) begin
            nxt = SEND;
          end else if (rd_addr != LAST_ADDR) begin
            nxt = RD;
          end else begin
            nxt = HOLD;
          end
`endif
        end
      end

      HOLD: begin
        if (!start) nxt = IDLE;
      end

      default: begin
        nxt = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers: counters, ownership, strobes and error flag
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_addr     <= '0;
      rd_addr     <= '0;
      byte_cnt    <= 3'd0;
      lane        <= 2'd0;
      sel_q       <= 1'b0;
      reset_cpu_q <= 1'b0;
      rx_err_q    <= 1'b0;
`ifdef IO_LOADER_CHECKSUM_EN
      sum         <= 8'd0;
      trailer     <= 1'b0;
`endif
    end else begin
      reset_cpu_q <= 1'b0;

      if (rx_done && (state != IDLE)) rx_err_q <= 1'b1;

      case (state)
        IDLE: begin
          if (rx_done) begin
            byte_cnt <= word_full ? 3'd0 : (byte_cnt + 3'd1);
          end else if (start && (byte_cnt == 3'd0)) begin
            rd_addr <= '0;
            lane    <= 2'd0;
            sel_q   <= 1'b0;
`ifdef IO_LOADER_CHECKSUM_EN
            sum     <= 8'd0;
            trailer <= 1'b0;
`endif
          end
        end

        WRITE: begin
          // The last word of the image releases the RAM to the CPU.
          if (wr_addr == LAST_ADDR) begin
            wr_addr     <= '0;
            sel_q       <= 1'b1;
            reset_cpu_q <= 1'b1;
          end else begin
            wr_addr <= wr_addr + 1'b1;
          end
        end

`ifdef IO_LOADER_CHECKSUM_EN
        SEND: begin
          if (!trailer) sum <= sum + shreg[7:0];
        end
`endif

        WAIT_TX: begin
`ifdef IO_LOADER_CHECKSUM_EN
          if (tx_done && !trailer) begin
            if (lane != LAST_LANE) begin
              lane <= lane + 2'd1;
            end else if (rd_addr != LAST_ADDR) begin
              rd_addr <= rd_addr + 1'b1;
              lane    <= 2'd0;
            end else begin
              trailer <= 1'b1;
            end
          end
`else
          if (tx_done) begin
            if (lane != LAST_LANE) begin
              lane <= lane + 2'd1;
            end else if (rd_addr != LAST_ADDR) begin
              rd_addr <= rd_addr + 1'b1;
              lane    <= 2'd0;
            end
          end
`endif
        end

        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Data registers: word assembly and read shift register.  These carry no
  // reset; a word is only written after BPW fresh bytes have been placed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if ((state == IDLE) && rx_done) begin
      for (int i = 0; i < BPW; i++) begin
        if (byte_cnt == 3'(i)) word[i*8 +: 8] <= rx_data;
      end
    end

    // Lane 0 is always at the bottom; each sent lane shifts the next one in.
    if (state == LATCH) begin
      shreg <= ram_rdata;
    end else if ((state == WAIT_TX) && tx_done && (lane != LAST_LANE)) begin
      shreg <= shreg >> 8;
    end
  end

endmodule

// File: tb/tb_io_loader.sv
// -----------------------------------------------------------------------------
// tb_io_loader
//
// Bench for io_loader with DEPTH=4, BPW=2, ADDR_W=2 (full address space).
// A behavioural image model is built from the received byte stream and the
// expected dump stream is derived from it; a small synchronous RAM and a
// transmitter with random latency surround the design.  Define
// IO_LOADER_CHECKSUM_EN for both files to exercise the trailer byte.
// -----------------------------------------------------------------------------
module tb_io_loader;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;
  localparam int BPW    = 2;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic                rx_done;
  logic [7:0]          rx_data;
  logic                tx_done;
  logic                tx_start;
  logic [7:0]          tx_data;
  logic [ADDR_W-1:0]   ram_addr;
  logic [8*BPW-1:0]    ram_wdata;
  logic                ram_we;
  logic [8*BPW-1:0]    ram_rdata;
  logic                reset_cpu;
  logic                sel;
  logic                busy;
  logic                rx_err;

  io_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BPW(BPW)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rx_done   (rx_done),
    .rx_data   (rx_data),
    .tx_done   (tx_done),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata),
    .reset_cpu (reset_cpu),
    .sel       (sel),
    .busy      (busy),
    .rx_err    (rx_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Synchronous RAM seen by the design.
  logic [8*BPW-1:0] mem [DEPTH];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  // Reference model: image contents and load pointer from the byte stream.
  int         model_word [DEPTH];
  int         model_ptr;
  logic [7:0] model_pend [$];
  int         exp_wr_addr [$];
  int         exp_wr_data [$];
  int         exp_rcpu;
  logic [7:0] exp_tx [$];

  task automatic model_reset();
    model_ptr = 0;
    model_pend.delete();
  endtask

  task automatic model_rx(input logic [7:0] b);
    int w;
    model_pend.push_back(b);
    if (model_pend.size() == BPW) begin
      w = 0;
      for (int i = 0; i < BPW; i++) w = w + (int'(model_pend[i]) << (8 * i));
      model_word[model_ptr] = w;
      exp_wr_addr.push_back(model_ptr);
      exp_wr_data.push_back(w);
      if (model_ptr == DEPTH - 1) begin
        model_ptr = 0;
        exp_rcpu++;
      end else begin
        model_ptr++;
      end
      model_pend.delete();
    end
  endtask

  task automatic fill_exp_tx();
    int sum;
    exp_tx.delete();
    sum = 0;
    for (int a = 0; a < DEPTH; a++) begin
      for (int l = 0; l < BPW; l++) begin
        exp_tx.push_back(8'((model_word[a] >> (8 * l)) & 255));
        sum = sum + ((model_word[a] >> (8 * l)) & 255);
      end
    end
`ifdef IO_LOADER_CHECKSUM_EN
    exp_tx.push_back(8'(sum % 256));
`endif
  endtask

  // Observation of the design's outputs, away from the active edge.
  int         cyc = 0;
  int         got_wr_addr [$];
  int         got_wr_data [$];
  logic [7:0] got_tx [$];
  int         got_rcpu;
  int         last_wr_cyc;
  int         rcpu_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (ram_we === 1'b1) begin
        got_wr_addr.push_back(int'(ram_addr));
        got_wr_data.push_back(int'(ram_wdata));
        last_wr_cyc = cyc;
      end
      if (tx_start === 1'b1) got_tx.push_back(tx_data);
      if (reset_cpu === 1'b1) begin
        got_rcpu++;
        rcpu_cyc = cyc;
      end
    end
  end

  // Transmitter: acknowledges each tx_start after a random delay; a reset
  // abandons the byte in flight.
  int tx_dmin = 1;
  int tx_dmax = 4;
  initial begin
    int d;
    tx_done = 1'b0;
    forever begin
      @(negedge clk);
      while (tx_start === 1'b1 && reset === 1'b0) begin
        d = $urandom_range(tx_dmax, tx_dmin);
        repeat (d) begin
          @(negedge clk);
          if (reset) break;
        end
        if (reset) break;
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
      end
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_busy"},      busy,      1'b0);
    check({pfx, "_sel"},       sel,       1'b0);
    check({pfx, "_tx_start"},  tx_start,  1'b0);
    check({pfx, "_tx_data"},   tx_data,   8'd0);
    check({pfx, "_ram_we"},    ram_we,    1'b0);
    check({pfx, "_ram_addr"},  ram_addr,  '0);
    check({pfx, "_ram_wdata"}, ram_wdata, '0);
    check({pfx, "_reset_cpu"}, reset_cpu, 1'b0);
    check({pfx, "_rx_err"},    rx_err,    1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    repeat ($urandom_range(4, 1)) @(negedge clk);
    model_rx(b);
  endtask

  task automatic check_writes(input string pfx);
    int n;
    check({pfx, "_wr_count"}, got_wr_addr.size(), exp_wr_addr.size());
    n = (got_wr_addr.size() < exp_wr_addr.size()) ? got_wr_addr.size() : exp_wr_addr.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_wr_addr%0d", pfx, i), got_wr_addr[i], exp_wr_addr[i]);
      check($sformatf("%s_wr_data%0d", pfx, i), got_wr_data[i], exp_wr_data[i]);
    end
    got_wr_addr.delete();
    got_wr_data.delete();
    exp_wr_addr.delete();
    exp_wr_data.delete();
  endtask

  // Drives start high, waits for the whole expected stream (optionally
  // injecting one stray rx byte mid-dump), then checks HOLD and release.
  task automatic run_dump(input string pfx, input bit inject);
    int  t;
    int  n;
    bit  done;
    fill_exp_tx();
    start = 1'b1;
    t = 0;
    done = 1'b0;
    while (got_tx.size() < exp_tx.size() && t < 3000) begin
      @(negedge clk);
      t++;
      if (inject && !done && got_tx.size() == 2) begin
        rx_data = 8'($urandom);
        rx_done = 1'b1;
        @(negedge clk);
        rx_done = 1'b0;
        done = 1'b1;
      end
    end
    repeat (12) @(negedge clk);
    check({pfx, "_tx_count"}, got_tx.size(), exp_tx.size());
    n = (got_tx.size() < exp_tx.size()) ? got_tx.size() : exp_tx.size();
    for (int i = 0; i < n; i++)
      check($sformatf("%s_tx%0d", pfx, i), got_tx[i], exp_tx[i]);
    check({pfx, "_hold_busy"}, busy, 1'b1);
    check({pfx, "_sel"}, sel, 1'b0);
    if (inject) check({pfx, "_rx_err"}, rx_err, 1'b1);
    start = 1'b0;
    @(negedge clk);
    check({pfx, "_release_busy"}, busy, 1'b0);
    got_tx.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    int         t;
    reset   = 1'b1;
    start   = 1'b0;
    rx_done = 1'b0;
    rx_data = 8'd0;
    exp_rcpu = 0;
    got_rcpu = 0;
    for (int i = 0; i < DEPTH; i++) model_word[i] = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    check_reset_outputs("por");

    // Fixed image 11..88: words 2211, 4433, 6655, 8877.
    for (int i = 1; i <= 8; i++) send_byte(8'(i * 8'h11));
    repeat (3) @(negedge clk);
    check_writes("load_fixed");
    check("load_fixed_rcpu_count", got_rcpu, exp_rcpu);
    check("load_fixed_rcpu_timing", rcpu_cyc - last_wr_cyc, 1);
    check("load_fixed_sel", sel, 1'b1);
    check("load_fixed_rx_err", rx_err, 1'b0);
    got_tx.delete();
    run_dump("dump_fixed", 1'b0);

    // Random image, then a dump with a stray byte arriving mid-stream.
    for (int i = 0; i < DEPTH * BPW; i++) send_byte(8'($urandom));
    repeat (3) @(negedge clk);
    check_writes("load_rand");
    check("load_rand_rcpu_count", got_rcpu, exp_rcpu);
    check("load_rand_sel", sel, 1'b1);
    got_tx.delete();
    run_dump("dump_rx_during", 1'b1);

    // Partial word pending blocks the dump until the word completes.
    apply_reset();
    @(negedge clk);
    check_reset_outputs("rst1");
    got_tx.delete();
    send_byte(8'($urandom));
    start = 1'b1;
    repeat (10) @(negedge clk);
    check("partial_no_tx", got_tx.size(), 0);
    check("partial_busy", busy, 1'b0);
    check("partial_no_write", got_wr_addr.size(), 0);
    send_byte(8'($urandom));
    run_dump("dump_after_partial", 1'b0);
    check_writes("partial");

    // Reset while waiting for the transmitter.
    tx_dmin = 6;
    tx_dmax = 8;
    got_tx.delete();
    start = 1'b1;
    t = 0;
    while (got_tx.size() < 1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("midrst_first_tx", got_tx.size(), 1);
    @(negedge clk);
    rx_data = 8'hA5;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
    check("midrst_busy_before", busy, 1'b1);
    check("midrst_rx_err_before", rx_err, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrst");
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    tx_dmin = 1;
    tx_dmax = 4;
    repeat (2) @(negedge clk);
    got_tx.delete();
    run_dump("dump_after_rst", 1'b0);
    check("final_no_writes", got_wr_addr.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/io_loader.md
IO_LOADER -- requirements
Module: io_loader

Interface
REQ-001 Parameter ADDR_W, default 16, RAM address width.
REQ-002 Parameter DEPTH, default 65536, words in RAM image; legal range 2..2^ADDR_W.
REQ-003 Parameter BPW, default 1, bytes per RAM word; legal range 1..4.
REQ-004 clk  input  1  sole clock; all logic on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 start  input  1  dump request, level-sensitive.
REQ-007 rx_done  input  1  one-cycle pulse; rx_data valid.
REQ-008 rx_data  input  8  received byte.
REQ-009 tx_done  input  1  one-cycle pulse; transmitter finished the current byte.
REQ-010 tx_start  output  1  one-cycle pulse; transmitter latches tx_data.
REQ-011 tx_data  output  8  byte to transmit.
REQ-012 ram_addr  output  ADDR_W  RAM address.
REQ-013 ram_wdata  output  8*BPW  RAM write data.
REQ-014 ram_we  output  1  RAM write strobe, one cycle per word.
REQ-015 ram_rdata  input  8*BPW  RAM read data, valid one cycle after ram_addr (synchronous RAM).
REQ-016 reset_cpu  output  1  one-cycle pulse when the image load completes.
REQ-017 sel  output  1  RAM owner; 1 = CPU, 0 = loader.
REQ-018 busy  output  1  high in every state except IDLE.
REQ-019 rx_err  output  1  sticky; a byte arrived while the loader could not accept it.

Function
REQ-020 A single FSM SHALL be used with states IDLE, WRITE, RD, LATCH, SEND, WAIT_TX, HOLD; load and dump never run concurrently.
REQ-021 In IDLE, rx_done SHALL place rx_data into byte lane byte_cnt (lane 0 = bits 7:0, little-endian) and increment byte_cnt; when byte_cnt reaches BPW, the FSM SHALL go to WRITE and byte_cnt SHALL clear.
REQ-022 WRITE SHALL last one cycle, with ram_we=1, ram_addr=wr_addr and ram_wdata=the assembled word, then return to IDLE.
REQ-023 On WRITE with wr_addr=DEPTH-1, the block SHALL set wr_addr to 0 and set sel to 1, and reset_cpu SHALL pulse high for exactly the next cycle; otherwise wr_addr SHALL increment.
REQ-024 In IDLE with start=1, rx_done=0 and byte_cnt=0, the block SHALL begin a dump: rd_addr to 0, lane to 0, sel to 0, then RD.
REQ-025 If rx_done and start are both asserted in IDLE, rx SHALL win; start is re-evaluated on the next cycle.
REQ-026 A dump SHALL NOT start while byte_cnt is nonzero, i.e. while a partial word is held.
REQ-027 The dump sequence SHALL be:
- RD drives ram_addr=rd_addr for one cycle.
- LATCH captures ram_rdata into a shift register.
- SEND drives tx_data=lane byte with tx_start=1 for one cycle.
- WAIT_TX holds until tx_done.
REQ-028 On tx_done in WAIT_TX, the next step SHALL be:
- lane<BPW-1: increment lane, go to SEND.
- otherwise, rd_addr<DEPTH-1: increment rd_addr, clear lane, go to RD.
- otherwise: go to HOLD.
REQ-029 HOLD SHALL return to IDLE only when start=0; a level-high start SHALL produce exactly one dump.
REQ-030 Any rx_done outside IDLE SHALL be discarded and SHALL set rx_err.
REQ-031 Address counters SHALL be ADDR_W+1 bits wide internally; comparisons against DEPTH-1 SHALL NOT overflow when DEPTH=2^ADDR_W.

Reset
REQ-032 Asserting reset SHALL immediately force the following values: state IDLE, tx_start 0, tx_data 0, ram_addr 0, ram_wdata 0, ram_we 0, reset_cpu 0, sel 0, busy 0, rx_err 0, wr_addr 0, rd_addr 0, byte_cnt 0, lane 0, and checksum 0 when configured in.
REQ-033 Reset mid-load or mid-dump SHALL abandon the operation; no partial word is written afterwards.

Configuration
REQ-034 With IO_LOADER_CHECKSUM_EN defined, the block SHALL keep an 8-bit modulo-256 sum of all dumped bytes and, after the last data byte's tx_done, SHALL send that sum as one extra byte (SEND/WAIT_TX) before HOLD; the sum SHALL clear at dump start.
REQ-035 Without IO_LOADER_CHECKSUM_EN, no trailer byte SHALL be sent and no checksum logic SHALL be present.

Verification
REQ-036 DEPTH=4, BPW=2; rx bytes 11,22,33,44,55,66,77,88 -> ram_we at addresses 0..3 with data 2211, 4433, 6655, 8877; reset_cpu pulses once after the 4th write; sel=1.
REQ-037 Same image, start=1 held -> tx bytes 11,22,...,88 with one tx_start per tx_done; HOLD until start=0; sel=0.
REQ-038 Checksum macro defined, same dump -> ninth byte 0x64 (sum of 0x11..0x88 mod 256).
REQ-039 rx_done during dump -> byte ignored, rx_err=1, dump output unchanged.
REQ-040 One byte received (BPW=2), then start -> no dump until the second byte completes the word.
REQ-041 reset asserted during WAIT_TX -> all outputs at reset values in the same cycle; the next start dumps from address 0.
